ex_advint_ctrl: RTL
===================

# ex_advint_ctrl

Issue sequencer and result buffer for the advanced integer (multiply/divide) unit. Sits between dispatch and the advint datapath. Accepts one operation at a time from dispatch over a valid/ready handshake and holds operands stable for the divide multicycle path. It pulses the datapath enable, captures the registered result into a 2-entry FIFO, and presents results to commit with stall backpressure.

## Interface
- DIV_CYCLES, 4: cycles operands are held stable before enable for divide ops (unit == 3'b100); legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- disp_valid  in  1  dispatch offers an op.
- disp_ready  out  1  controller accepts an op this cycle.
- disp_in1, disp_in2  in  64  operands.
- disp_rd, disp_rd2  in  6  destination register numbers.
- disp_unit  in  3  sub-unit select.
- disp_op  in  2  operation select.
- au_in1, au_in2  out  64  operands to datapath (registered).
- au_unit  out  3  registered copy of the accepted unit.
- au_op  out  2  registered copy of the accepted op.
- au_rd, au_rd2  out  6  registered destination numbers.
- au_enable  out  1  one-cycle execute pulse.
- au_valid  in  1  datapath result valid (one cycle after au_enable).
- au_out, au_out2  in  64  datapath results.
- au_rd_out, au_rd2_out  in  6  datapath-returned destination numbers.
- cm_valid  out  1  FIFO head valid.
- cm_out, cm_out2  out  64  FIFO head results.
- cm_rd, cm_rd2  out  6  FIFO head destinations.
- cm_stall  in  1  commit cannot take the head this cycle.
- err  out  1  sticky protocol-error flag.

## Operation
- FSM states: IDLE, HOLD, ISSUE, CAPT.
- disp_ready = (state == IDLE) && (fifo_count < 2). Combinational, no dependence on disp_valid.
- Accept on an edge with disp_valid && disp_ready: latch all disp_* into au_* registers.
  - Divide op with DIV_CYCLES > 1: go to HOLD with hold_cnt = DIV_CYCLES-1.
  - Otherwise: go to ISSUE.
- HOLD: decrement hold_cnt each cycle. When hold_cnt == 1, go to ISSUE. au_enable = 0.
- ISSUE: au_enable = 1 for exactly this cycle, then go to CAPT.
- CAPT, au_valid = 1: push {au_out, au_out2, au_rd_out, au_rd2_out}, then go to IDLE.
- CAPT, au_valid = 0: set err, go to IDLE, no push.
- au_valid in IDLE or HOLD: ignored, sets err.
- au_* registers hold their value until the next accept.
- FIFO: 2 entries, 1-bit wrapping read/write pointers, 2-bit count.
  - Pop on cm_valid && !cm_stall.
  - Simultaneous push and pop: count unchanged; head advances and new entry is written.
  - Overflow is impossible because disp_ready gates on count < 2 and only one op is in flight.
- err clears only on reset.

## Timing
- Reset values:
  - state IDLE; FIFO empty.
  - au_enable, au_in1, au_in2, au_unit, au_op, au_rd, au_rd2 all 0.
  - cm_valid, cm_out, cm_out2, cm_rd, cm_rd2 all 0.
  - err 0.
  - disp_ready 0 while rst_n is low; 1 in the first cycle after release.
- Non-divide latency: accept edge E → au_enable in cycle E+1 → au_valid in cycle E+2 → cm_valid in cycle E+3.
- Divide latency: cm_valid at E + DIV_CYCLES + 2.
- Throughput: at most one accept per 3 cycles (non-divide).
- cm_* are FIFO outputs: stable while cm_stall is high, changing only after a pop or a push into an empty FIFO.
- Reset mid-operation: the in-flight op is discarded, FIFO is flushed, and a late au_valid after reset is ignored.

## Configuration
- EX_ADVINT_CTRL_PERF_EN defined: adds two output ports, each a 32-bit wrapping counter reset to 0.
  - perf_issued: increments on each au_enable.
  - perf_stall: increments each cycle with cm_valid && cm_stall.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset release, then a single mul op (in1 = 3, in2 = 5, rd = 7, datapath model returns 15 with rd 7): disp_ready = 1 in the first post-reset cycle; au_enable pulses at E+1; cm_valid = 1, cm_out = 15, cm_rd = 7 at E+3; cm_valid = 0 after the pop.
- Divide op with DIV_CYCLES = 4: au_in1/au_in2 are stable for 3 HOLD cycles; au_enable first rises at E+4; cm_valid at E+6.
- cm_stall held high across three ops (results 1, 2, 3): the first two fill the FIFO; disp_ready stays 0 while the third is offered. Releasing the stall pops 1 then 2; the third is then accepted and 3 is delivered.
- Push and pop on the same edge with count = 1: count stays 1; the head order is preserved.
- au_valid withheld in CAPT: err = 1 and stays 1; state returns to IDLE; no FIFO entry is created.
- Reset asserted in HOLD: au_enable never pulses; all outputs read 0; after release, cm_valid stays 0.

Source files
------------

// File: rtl/ex_advint_ctrl.sv
// Issue sequencer and 2-entry result FIFO between dispatch and the advint (mul/div) datapath.
// Define EX_ADVINT_CTRL_PERF_EN to add the perf_issued / perf_stall counters.
module ex_advint_ctrl #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_valid,
    output logic        disp_ready,
    input  logic [63:0] disp_in1,
    input  logic [63:0] disp_in2,
    input  logic [5:0]  disp_rd,
    input  logic [5:0]  disp_rd2,
    input  logic [2:0]  disp_unit,
    input  logic [1:0]  disp_op,
    output logic [63:0] au_in1,
    output logic [63:0] au_in2,
    output logic [2:0]  au_unit,
    output logic [1:0]  au_op,
    output logic [5:0]  au_rd,
    output logic [5:0]  au_rd2,
    output logic        au_enable,
    input  logic        au_valid,
    input  logic [63:0] au_out,
    input  logic [63:0] au_out2,
    input  logic [5:0]  au_rd_out,
    input  logic [5:0]  au_rd2_out,
    output logic        cm_valid,
    output logic [63:0] cm_out,
    output logic [63:0] cm_out2,
    output logic [5:0]  cm_rd,
    output logic [5:0]  cm_rd2,
    input  logic        cm_stall,
    output logic        err
`ifdef EX_ADVINT_CTRL_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, HOLD, ISSUE, CAPT} state_t;

    typedef struct packed {
        logic [63:0] out;
        logic [63:0] out2;
        logic [5:0]  rd;
        logic [5:0]  rd2;
    } entry_t;

    localparam logic [3:0] HOLD_INIT = 4'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic       err_q, err_d;
    logic       accept, push, pop;
    entry_t     fifo_q [2];
    entry_t     head;
    logic       wptr_q, rptr_q;
    logic [1:0] count_q;

    // Held low during reset so dispatch never sees a ready before the block is live.
    assign disp_ready = rst_n && (state_q == IDLE) && (count_q < 2'd2);
    assign accept     = disp_valid && disp_ready;
    assign au_enable  = (state_q == ISSUE);
    assign pop        = (count_q != 2'd0) && !cm_stall;
    assign err        = err_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        err_d   = err_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (au_valid) err_d = 1'b1;
                if (accept) begin
                    if ((disp_unit == 3'b100) && (DIV_CYCLES > 1)) begin
                        state_d = HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (au_valid) err_d = 1'b1;
                hold_d = hold_q - 4'd1;
                if (hold_q == 4'd1) state_d = ISSUE;
            end
            ISSUE: state_d = CAPT;
            CAPT: begin
                if (au_valid) push = 1'b1;
                else          err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            err_q   <= 1'b0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
            au_in1  <= '0;
            au_in2  <= '0;
            au_unit <= '0;
            au_op   <= '0;
            au_rd   <= '0;
            au_rd2  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            if (accept) begin
                au_in1  <= disp_in1;
                au_in2  <= disp_in2;
                au_unit <= disp_unit;
                au_op   <= disp_op;
                au_rd   <= disp_rd;
                au_rd2  <= disp_rd2;
            end
            if (push) wptr_q <= ~wptr_q;
            if (pop)  rptr_q <= ~rptr_q;
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= '{out: au_out, out2: au_out2, rd: au_rd_out, rd2: au_rd2_out};
    end

    assign head     = fifo_q[rptr_q];
    assign cm_valid = (count_q != 2'd0);
    assign cm_out   = cm_valid ? head.out  : '0;
    assign cm_out2  = cm_valid ? head.out2 : '0;
    assign cm_rd    = cm_valid ? head.rd   : '0;
    assign cm_rd2   = cm_valid ? head.rd2  : '0;

`ifdef EX_ADVINT_CTRL_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (au_enable)             perf_issued_q <= perf_issued_q + 32'd1;
            if (cm_valid && cm_stall)  perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
